ram_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer for the single-port data RAM (10-bit word address, 32-bit data, registered read output).
- Requester 0 is the core's load/store path. Requester 1 is the program loader/debug port.
- Grants one transaction at a time using round-robin, drives the RAM, waits out the read latency, and returns read data with a done pulse.
- Replaces direct databus-to-RAM wiring in top_rv.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arbiter_rr_arb2.sv | 28 ++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter and its round-robin picker.
package ram_arb_pkg;

   localparam int AW_DEF     = 10;
   localparam int DW_DEF     = 32;
   localparam int RD_LAT_DEF = 2;

   // Wide enough for a read-latency countdown up to 7 cycles
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef logic port_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// port that did not win last time is chosen.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       rr_last,
   output logic [1:0] gnt,
   output logic       winner
);

   port_t pick;

   always_comb begin
      pick = 1'b0;
      if (req == 2'b11) begin
         pick = ~rr_last;
      end else begin
         pick = req[1];
      end
      gnt = 2'b00;
      if (req != 2'b00) begin
         gnt[pick] = 1'b1;
      end
      winner = pick;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates requester 0 (load/store) and requester 1 (loader/debug) onto the
// single-port data RAM, one transaction at a time, returning data with a done pulse.
//
//   state | meaning
//   IDLE  | no access in flight; grants (Mealy) and latches the winner's access
//   ISSUE | RAM sees the latched access for one cycle; writes finish here
//   WAIT  | read in flight; count down the RAM read latency, then capture data
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   state_t           state_q, state_d;
   logic [AW-1:0]    ram_addr_q, ram_addr_d;
   logic [DW-1:0]    ram_din_q, ram_din_d;
   logic             ram_we_q, ram_we_d;
   port_t            owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rr_last_q, rr_last_d;
   logic             m0_done_q, m0_done_d;
   logic             m1_done_q, m1_done_d;
   logic [DW-1:0]    m0_rdata_q, m0_rdata_d;
   logic [DW-1:0]    m1_rdata_q, m1_rdata_d;

   logic [1:0]       arb_gnt;
   logic             arb_winner;
   logic             grant_en;

   rr_arb2 u_rr_arb2 (
      .req     ({m1_req, m0_req}),
      .rr_last (rr_last_q),
      .gnt     (arb_gnt),
      .winner  (arb_winner)
   );

   // Grants only exist in IDLE and are suppressed while reset is asserted
   assign grant_en = rst && (state_q == IDLE);
   assign m0_gnt   = grant_en && arb_gnt[0];
   assign m1_gnt   = grant_en && arb_gnt[1];

   always_comb begin
      state_d    = state_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_we_d   = ram_we_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      rr_last_d  = rr_last_q;
      m0_done_d  = 1'b0;
      m1_done_d  = 1'b0;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;

      case (state_q)
         IDLE: begin
            ram_we_d = 1'b0;
            if (arb_gnt != 2'b00) begin
               owner_d   = arb_winner;
               rr_last_d = arb_winner;
               state_d   = ISSUE;
               if (arb_winner) begin
                  ram_addr_d = m1_addr;
                  ram_din_d  = m1_wdata;
                  ram_we_d   = m1_we;
               end else begin
                  ram_addr_d = m0_addr;
                  ram_din_d  = m0_wdata;
                  ram_we_d   = m0_we;
               end
            end
         end
         ISSUE: begin
            ram_we_d = 1'b0;
            if (ram_we_q) begin
               state_d = IDLE;
               if (owner_q) begin
                  m1_done_d = 1'b1;
               end else begin
                  m0_done_d = 1'b1;
               end
            end else begin
               cnt_d   = CNT_W'(RD_LAT - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               if (owner_q) begin
                  m1_rdata_d = ram_dout;
                  m1_done_d  = 1'b1;
               end else begin
                  m0_rdata_d = ram_dout;
                  m0_done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            ram_we_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         ram_we_q   <= 1'b0;
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         rr_last_q  <= 1'b1;
         m0_done_q  <= 1'b0;
         m1_done_q  <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         ram_we_q   <= ram_we_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         rr_last_q  <= rr_last_d;
         m0_done_q  <= m0_done_d;
         m1_done_q  <= m1_done_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign ram_we   = ram_we_q;
   assign m0_done  = m0_done_q;
   assign m1_done  = m1_done_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: three instances (RD_LAT 2, 1, 5) driven by shared tasks,
// each with its own RAM model and a transaction-level reference model.
module tb_ram_arbiter;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   rel_cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [2*N-1:0]    req_v = '0;
   logic [2*N-1:0]    we_v = '0;
   logic [2*N*10-1:0] addr_v = '0;
   logic [2*N*32-1:0] wdata_v = '0;
   logic [2*N-1:0]    gnt_v;
   logic [2*N-1:0]    done_v;
   logic [2*N*32-1:0] rdata_v;
   logic [N-1:0]      busy_v;
   logic [N-1:0]      ram_we_v;
   int                order_q [N][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
   endfunction

   function automatic logic [31:0] init_word(input int a);
      return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the done cycle
   task automatic txn(input int k, input int p, input logic we, input logic [9:0] a,
                      input logic [31:0] d, output int g, output int dn, output logic [31:0] rd);
      int idx = 2 * k + p;
      bit ok = 1'b0;
      g  = -1;
      dn = -1;
      rd = '0;
      we_v[idx]             = we;
      addr_v[idx*10 +: 10]  = a;
      wdata_v[idx*32 +: 32] = d;
      req_v[idx]            = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (gnt_v[idx]) begin
            ok = 1'b1;
            g  = cyc;
         end
      end
      if (!ok) begin
         chk($sformatf("L%0d p%0d gnt_timeout", lat_of(k), p), 32'(ok), 1);
         req_v[idx] = 1'b0;
         @(posedge clk); #1;
         return;
      end
      order_q[k].push_back(p);
      @(posedge clk); #1;
      req_v[idx] = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (done_v[idx]) begin
            ok = 1'b1;
            dn = cyc;
            rd = rdata_v[idx*32 +: 32];
         end
      end
      if (!ok) chk($sformatf("L%0d p%0d done_timeout", lat_of(k), p), 32'(ok), 1);
      @(posedge clk); #1;
   endtask

   task automatic directed_a(input int k);
      int g, dn;
      logic [31:0] rd;
      string s = $sformatf("L%0d", lat_of(k));
      txn(k, 0, 1'b1, 10'h004, 32'hDEAD_BEEF, g, dn, rd);
      chk({s, " first_gnt_cycle"}, 32'(g), 32'(rel_cyc));
      chk({s, " wr_lat"}, 32'(dn - g), 2);
      txn(k, 0, 1'b0, 10'h004, 32'h0, g, dn, rd);
      chk({s, " rd_lat"}, 32'(dn - g), 32'(lat_of(k) + 2));
      chk({s, " rd_data"}, rd, 32'hDEAD_BEEF);
      txn(k, 0, 1'b1, 10'h010, 32'hA5A5_A5A5, g, dn, rd);
      txn(k, 0, 1'b0, 10'h010, 32'h0, g, dn, rd);
      chk({s, " m0_old_rdata"}, rd, 32'hA5A5_A5A5);
      txn(k, 1, 1'b1, 10'h3FF, 32'h1234_5678, g, dn, rd);
      chk({s, " m1_wr_lat"}, 32'(dn - g), 2);
      txn(k, 1, 1'b0, 10'h3FF, 32'h0, g, dn, rd);
      chk({s, " m1_rd_data"}, rd, 32'h1234_5678);
      chk({s, " m0_rdata_held"}, rdata_v[(2*k)*32 +: 32], 32'hA5A5_A5A5);
   endtask

   task automatic rnd_port(input int k, input int p, input int n, input int max_gap, input int base);
      int g, dn;
      logic [31:0] rd;
      for (int j = 0; j < n; j++) begin
         repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk); #1;
         end
         txn(k, p, 1'($urandom_range(0, 1)), 10'(base + int'($urandom_range(0, 15))),
             $urandom, g, dn, rd);
      end
   endtask

   task automatic post_reset_read(input int k);
      int g, dn;
      logic [31:0] rd;
      string s = $sformatf("L%0d", lat_of(k));
      txn(k, 0, 1'b0, 10'h004, 32'h0, g, dn, rd);
      chk({s, " post_rst_rd_lat"}, 32'(dn - g), 32'(lat_of(k) + 2));
      chk({s, " post_rst_rd_data"}, rd, 32'hDEAD_BEEF);
   endtask

   for (genvar i = 0; i < N; i++) begin : g_inst
      localparam int L = (i == 0) ? 2 : ((i == 1) ? 1 : 5);
      logic [9:0]  ram_addr;
      logic [31:0] ram_din;
      logic [31:0] ram_dout;
      logic [31:0] mem [int];
      logic [31:0] pipe [8];

      ram_arbiter #(.AW(10), .DW(32), .RD_LAT(L)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .m0_req   (req_v[2*i]),
         .m0_we    (we_v[2*i]),
         .m0_addr  (addr_v[(2*i)*10 +: 10]),
         .m0_wdata (wdata_v[(2*i)*32 +: 32]),
         .m0_gnt   (gnt_v[2*i]),
         .m0_done  (done_v[2*i]),
         .m0_rdata (rdata_v[(2*i)*32 +: 32]),
         .m1_req   (req_v[2*i+1]),
         .m1_we    (we_v[2*i+1]),
         .m1_addr  (addr_v[(2*i+1)*10 +: 10]),
         .m1_wdata (wdata_v[(2*i+1)*32 +: 32]),
         .m1_gnt   (gnt_v[2*i+1]),
         .m1_done  (done_v[2*i+1]),
         .m1_rdata (rdata_v[(2*i+1)*32 +: 32]),
         .ram_addr (ram_addr),
         .ram_din  (ram_din),
         .ram_we   (ram_we_v[i]),
         .ram_dout (ram_dout),
         .busy     (busy_v[i])
      );

      // RAM: data for an address presented in cycle c is on ram_dout in cycle c+L
      always @(posedge clk) begin
         pipe[0] <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : init_word(int'(ram_addr));
         for (int st = 1; st < 8; st++) pipe[st] <= pipe[st-1];
         if (ram_we_v[i]) mem[int'(ram_addr)] = ram_din;
      end
      assign ram_dout = pipe[L-1];

      // Reference: one outstanding transaction, known completion cycle, shadow memory
      int          free_at = 0;
      int          pg = 0;
      int          pdone = 0;
      int          pport = 0;
      bit          pval = 1'b0;
      bit          pwe = 1'b0;
      bit          rr_last = 1'b1;
      bit          armed = 1'b0;
      logic [9:0]  paddr = '0;
      logic [31:0] pdin = '0;
      logic [31:0] pdata = '0;
      logic [31:0] shadow [int];
      logic [31:0] exp_rd [2] = '{32'h0, 32'h0};

      always @(negedge clk) begin
         int          w;
         int          idx;
         logic [1:0]  rq;
         bit          dexp;
         string       s;
         s  = $sformatf("L%0d", L);
         rq = {req_v[2*i+1], req_v[2*i]};
         if (armed) begin
            w = -1;
            if (rst && cyc >= free_at && rq != 2'b00)
               w = (rq == 2'b11) ? (rr_last ? 0 : 1) : (rq[1] ? 1 : 0);
            chk({s, " gnt0"}, 32'(gnt_v[2*i]), 32'(w == 0));
            chk({s, " gnt1"}, 32'(gnt_v[2*i+1]), 32'(w == 1));
            for (int p = 0; p < 2; p++) begin
               dexp = pval && pport == p && cyc == pdone;
               if (dexp && !pwe) exp_rd[p] = pdata;
               chk($sformatf("%s done%0d", s, p), 32'(done_v[2*i+p]), 32'(dexp));
               chk($sformatf("%s rdata%0d", s, p), rdata_v[(2*i+p)*32 +: 32], exp_rd[p]);
            end
            chk({s, " ram_we"}, 32'(ram_we_v[i]), 32'(pval && pwe && cyc == pg + 1));
            if (pval && cyc == pg + 1) begin
               chk({s, " ram_addr"}, 32'(ram_addr), 32'(paddr));
               if (pwe) chk({s, " ram_din"}, ram_din, pdin);
            end
            chk({s, " busy"}, 32'(busy_v[i]), 32'(pval && cyc > pg && cyc < pdone));
            if (pval && cyc >= pdone) pval = 1'b0;
            if (w >= 0) begin
               idx     = 2 * i + w;
               pval    = 1'b1;
               pg      = cyc;
               pport   = w;
               pwe     = we_v[idx];
               paddr   = addr_v[idx*10 +: 10];
               pdin    = wdata_v[idx*32 +: 32];
               pdone   = cyc + (pwe ? 2 : L + 2);
               free_at = pdone;
               rr_last = (w == 1);
               if (pwe) shadow[int'(paddr)] = pdin;
               else pdata = shadow.exists(int'(paddr)) ? shadow[int'(paddr)] : init_word(int'(paddr));
            end
         end
         if (!rst) begin
            armed     = 1'b1;
            pval      = 1'b0;
            free_at   = cyc + 1;
            rr_last   = 1'b1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      for (int k = 0; k < N; k++) begin
         we_v[2*k]              = 1'b1;
         addr_v[(2*k)*10 +: 10] = 10'h004;
         wdata_v[(2*k)*32 +: 32] = 32'hDEAD_BEEF;
         req_v[2*k]             = 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            chk($sformatf("L%0d rst_gnt0", lat_of(k)), 32'(gnt_v[2*k]), 0);
            if (c > 0) begin
               chk($sformatf("L%0d rst_ram_we", lat_of(k)), 32'(ram_we_v[k]), 0);
               chk($sformatf("L%0d rst_busy", lat_of(k)), 32'(busy_v[k]), 0);
            end
         end
      end
      @(posedge clk); #1;
      rst     = 1'b1;
      rel_cyc = cyc;

      for (int k = 0; k < N; k++) begin
         automatic int kk = k;
         fork directed_a(kk); join_none
      end
      wait fork;

      // Sustained contention: both ports re-request immediately after their done
      for (int k = 0; k < N; k++) order_q[k].delete();
      for (int k = 0; k < N; k++) begin
         automatic int kk = k;
         fork
            rnd_port(kk, 0, 4, 0, 'h100);
            rnd_port(kk, 1, 4, 0, 'h100);
         join_none
      end
      wait fork;
      for (int k = 0; k < N; k++) begin
         chk($sformatf("L%0d contend_count", lat_of(k)), 32'(order_q[k].size()), 8);
         for (int j = 0; j < order_q[k].size(); j++)
            chk($sformatf("L%0d contend_order%0d", lat_of(k), j), 32'(order_q[k][j]), 32'(j % 2));
      end

      // Reset while each instance is in the read-wait phase
      for (int k = 0; k < N; k++) begin
         we_v[2*k]              = 1'b0;
         addr_v[(2*k)*10 +: 10] = 10'h004;
         req_v[2*k]             = 1'b1;
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) chk($sformatf("L%0d mr_gnt", lat_of(k)), 32'(gnt_v[2*k]), 1);
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) req_v[2*k] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (8) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            chk($sformatf("L%0d mr_done", lat_of(k)), 32'(done_v[2*k]), 0);
            chk($sformatf("L%0d mr_rdata", lat_of(k)), rdata_v[(2*k)*32 +: 32], 0);
            chk($sformatf("L%0d mr_busy", lat_of(k)), 32'(busy_v[k]), 0);
            chk($sformatf("L%0d mr_ram_we", lat_of(k)), 32'(ram_we_v[k]), 0);
         end
      end
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
         automatic int kk = k;
         fork post_reset_read(kk); join_none
      end
      wait fork;

      for (int k = 0; k < N; k++) begin
         automatic int kk = k;
         fork
            rnd_port(kk, 0, 25, 3, 'h200);
            rnd_port(kk, 1, 25, 3, 'h200);
         join_none
      end
      wait fork;

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
